sp_ram_frame_ctrl: RTL and testbench
====================================

Name: sp_ram_frame_ctrl

Overview:
- Frame buffer controller that sits directly upstream of the 64x16 single-port RAM with enable. It drives the RAM's en/we/a/di and consumes its do.
- Accepts one frame of 16-bit words on a valid/ready input stream and writes it into the RAM. It then streams the frame back out on a valid/ready output stream.
- Fill and drain alternate, because the RAM has one port. Used as a packet store-and-forward stage.

Parameters:
- DATA_W, 16, word width; must equal RAM data width.
- ADDR_W, 6, RAM address width.
- DEPTH, 64, RAM words; must equal 2**ADDR_W.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid and s_ready.
- s_data  in  DATA_W  input word.
- s_last  in  1  marks the final word of the input frame.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the output word.
- m_data  out  DATA_W  output word; wired directly to ram_do.
- m_last  out  1  marks the final word of the output frame.
- frame_len  out  ADDR_W+1  word count of the frame currently held; range 1..DEPTH.
- trunc  out  1  one-cycle pulse when a frame is closed by a full RAM with no s_last.
- ram_en  out  1  to RAM en.
- ram_we  out  1  to RAM we.
- ram_a  out  ADDR_W  to RAM a.
- ram_di  out  DATA_W  to RAM di.
- ram_do  in  DATA_W  from RAM do (RAM registers the address when en=1; do follows the registered address).

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=INIT; wr_ptr=0, rd_ptr=0, frame_len=0.
  - Outputs: s_ready=0, m_valid=0, m_last=0, trunc=0, ram_en=0, ram_we=0.
  - A reset in the middle of a frame discards the frame.
- States: INIT -> FILL -> RD_ISSUE -> DRAIN -> FILL. All outputs decode from registered state and counters.
- INIT: lasts one cycle, then goes to FILL.
- FILL:
  - s_ready=1; ram_a=wr_ptr; ram_di=s_data.
  - ram_en = ram_we = s_valid (a write occurs only on an accepted word).
  - On each accepted word, wr_ptr increments.
  - The frame closes on an accepted word with s_last=1, or on an accepted word at wr_ptr=DEPTH-1 (full).
  - On close: frame_len = wr_ptr+1, wr_ptr=0, next state RD_ISSUE.
  - trunc pulses in the cycle after a close caused by full with s_last=0.
  - Accepting s_last=1 at wr_ptr=DEPTH-1 gives frame_len=DEPTH and trunc=0.
- RD_ISSUE:
  - s_ready=0, m_valid=0; ram_en=1, ram_we=0, ram_a=0; rd_ptr=0.
  - Next state DRAIN.
- DRAIN:
  - m_valid=1; m_data=ram_do; m_last = (rd_ptr == frame_len-1).
  - On handshake (m_valid and m_ready):
    - If not the last word: ram_en=1, ram_a=rd_ptr+1, rd_ptr increments. The next word is valid the following cycle, so throughput is one word per clock.
    - If the last word: ram_en=0, next state FILL.
  - With no handshake, ram_en=0. The RAM's registered address holds, so m_data stays stable under backpressure.
  - Downstream must not see m_data change while m_valid=1 and m_ready=0.
- Latency:
  - Input accept to the RAM write edge: 0 cycles.
  - Frame close to first m_valid: 2 cycles (RD_ISSUE, then DRAIN).
  - Last output handshake to s_ready=1: 1 cycle.
- No overlap: s_ready=0 throughout RD_ISSUE and DRAIN.
- frame_len holds its value until the next frame closes.
- Pointer widths:
  - wr_ptr and rd_ptr are ADDR_W bits and never wrap within a frame.
  - frame_len is ADDR_W+1 bits so it can hold DEPTH.

Decomposition:
- Shared package holds:
  - state enum {INIT, FILL, RD_ISSUE, DRAIN};
  - constants DATA_W=16, ADDR_W=6, DEPTH=64.
- No sub-module inside the block.
- The top-level test wrapper instantiates sp_ram_frame_ctrl plus the existing single-port RAM with enable.

Test Plan:
- Frame of 3 words 0x1111, 0x2222, 0x3333 (s_last on the third), m_ready=1 -> RAM writes at a=0,1,2; m_valid rises 2 cycles after close; outputs 0x1111, 0x2222, 0x3333 on consecutive cycles; m_last on 0x3333; frame_len=3; trunc=0.
- 64 words 0x0000..0x003F with s_last=0 -> close after word 63; trunc pulses once; frame_len=64; 64 words read back in order; m_last on 0x003F.
- Backpressure: 4-word frame, m_ready toggles 1,0,0,1,... -> m_data stable while stalled; ram_en=0 during stalls; no word lost or duplicated.
- s_valid asserted during DRAIN -> s_ready=0 and no RAM write (ram_we=0); after the last handshake, s_ready=1 the next cycle; the next frame is stored from a=0.
- 1-word frame 0xBEEF with s_last=1 -> frame_len=1; a single output word with m_last=1; return to FILL.
- rst_n=0 for 1 cycle mid-DRAIN at word 2 of 5 -> m_valid=0, s_ready=0 during the INIT cycle; then s_ready=1; the old frame is never emitted.

Source files
------------

// File: rtl/sp_ram_frame_ctrl_pkg.sv
// Shared definitions for the single-port RAM frame buffer controller.
//   DATA_W : word width, equal to the RAM data width
//   ADDR_W : RAM address width
//   DEPTH  : RAM word count (2**ADDR_W)
//   state_t: controller states INIT -> FILL -> RD_ISSUE -> DRAIN -> FILL
package sp_ram_frame_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    FILL     = 2'd1,
    RD_ISSUE = 2'd2,
    DRAIN    = 2'd3
  } state_t;

endpackage

// File: rtl/sp_ram_frame_ctrl.sv
// Store-and-forward frame buffer controller in front of a single-port RAM
// with enable. One frame is written into the RAM from the s_* stream, then
// read back out on the m_* stream; fill and drain alternate because the RAM
// has a single port.
//
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   s_valid/s_ready   : input stream handshake
//   s_data, s_last    : input word and end-of-frame marker
//   m_valid/m_ready   : output stream handshake
//   m_data, m_last    : output word (straight from ram_do) and end marker
//   frame_len         : word count of the frame currently held (1..DEPTH)
//   trunc             : one-cycle pulse when a full RAM closed a frame
//                       that had no s_last
//   ram_en/we/a/di    : RAM control, address and write data
//   ram_do            : RAM read data (follows the RAM's registered address)
module sp_ram_frame_ctrl
  import sp_ram_frame_ctrl_pkg::*;
#(
  parameter int DATA_W = sp_ram_frame_ctrl_pkg::DATA_W,
  parameter int ADDR_W = sp_ram_frame_ctrl_pkg::ADDR_W,
  parameter int DEPTH  = sp_ram_frame_ctrl_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [ADDR_W:0]   frame_len,
  output logic              trunc,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do
);

  localparam int LEN_W = ADDR_W + 1;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [LEN_W-1:0]    len_q;
  logic                trunc_q;

  logic                s_accept;
  logic                wr_full;
  logic                fill_close;
  logic                rd_last;

  assign s_accept   = (state_q == FILL) && s_valid;
  assign wr_full    = (wr_ptr == ADDR_W'(DEPTH - 1));
  assign fill_close = s_accept && (s_last || wr_full);
  assign rd_last    = ({1'b0, rd_ptr} == (len_q - LEN_W'(1)));

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:     state_d = FILL;
      FILL:     if (fill_close) state_d = RD_ISSUE;
      RD_ISSUE: state_d = DRAIN;
      DRAIN:    if (m_ready && rd_last) state_d = FILL;
      default:  state_d = INIT;
    endcase
  end

  // ---------------------------------------------------------------------
  // Pointers, frame length and truncation flag
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      len_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      // A full-RAM close without s_last marks the stored frame as cut short.
      trunc_q <= fill_close && !s_last;

      if (s_accept) begin
        if (fill_close) begin
          wr_ptr <= '0;
          len_q  <= {1'b0, wr_ptr} + LEN_W'(1);
        end else begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
        end
      end

      if (state_q == RD_ISSUE) begin
        rd_ptr <= '0;
      end else if ((state_q == DRAIN) && m_ready && !rd_last) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    ram_a   = '0;
    case (state_q)
      FILL: begin
        s_ready = 1'b1;
        ram_en  = s_valid;
        ram_we  = s_valid;
        ram_a   = wr_ptr;
      end
      RD_ISSUE: begin
        // Prime the RAM read of word 0 so it is on ram_do when DRAIN starts.
        ram_en = 1'b1;
        ram_a  = '0;
      end
      DRAIN: begin
        m_valid = 1'b1;
        // Fetch the next word only on a handshake; while stalled the RAM's
        // registered address holds and m_data stays put.
        if (m_ready && !rd_last) begin
          ram_en = 1'b1;
          ram_a  = rd_ptr + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign m_last    = (state_q == DRAIN) && rd_last;
  assign m_data    = ram_do;
  assign ram_di    = s_data;
  assign frame_len = len_q;
  assign trunc     = trunc_q;

endmodule

// File: tb/tb_sp_ram_frame_ctrl.sv
// Scoreboard bench for sp_ram_frame_ctrl with a behavioural 64x16 RAM.
module tb_sp_ram_frame_ctrl;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int DP = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [AW:0]   frame_len;
  logic          trunc;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;

  always #5 clk = ~clk;

  sp_ram_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .frame_len(frame_len), .trunc(trunc),
    .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
    .ram_do(ram_do)
  );

  // Single-port RAM with enable: address registered when en=1.
  logic [DW-1:0] mem [DP];
  logic [AW-1:0] a_q = '0;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_a] <= ram_di;
      a_q <= ram_a;
    end
  end
  assign ram_do = mem[a_q];

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            len;
    bit            first;
    int            close_cyc;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] cur_words[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            exp_trunc = 0;
  int            seen_trunc = 0;
  int            rmode = 0;
  int            ridx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: the accepted word stream is cut into frames at each
  // s_last or whenever 64 words have piled up; each frame comes back in order.
  task automatic model_accept(input logic [DW-1:0] d, input logic l, input int cc);
    int n;
    cur_words.push_back(d);
    if (l || cur_words.size() == DP) begin
      n = cur_words.size();
      for (int i = 0; i < n; i++)
        exp_q.push_back('{data: cur_words[i], last: (i == n - 1), len: n,
                          first: (i == 0), close_cyc: cc});
      if (!l) exp_trunc++;
      cur_words.delete();
    end
  endtask

  // Offer one word (after an optional idle gap) and wait for it to be taken.
  task automatic send_word(input logic [DW-1:0] d, input logic l, input int gap);
    int waited;
    s_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    waited  = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      waited++;
      if (waited > 500) begin
        check("s_ready_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        return;
      end
    end
    check("wr_addr", ram_a, cur_words.size());
    check("wr_we", {ram_en, ram_we}, 2'b11);
    check("wr_data", ram_di, d);
    model_accept(d, l, cyc);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("drain_done", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // m_ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
  always @(posedge clk) begin
    #1;
    ridx++;
    case (rmode)
      0:       m_ready = 1'b1;
      1:       m_ready = (ridx % 3 == 0);
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: samples on the falling edge, pops the scoreboard on handshakes.
  logic          prev_rst = 1'b0;
  logic          prev_mv = 1'b0;
  logic          held = 1'b0;
  logic [DW-1:0] held_data = '0;
  logic          pend_sready = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!prev_rst) begin
      // The last edge applied reset: controller is in INIT.
      check("init_s_ready", s_ready, 1'b0);
      check("init_m_valid", m_valid, 1'b0);
      check("init_ram_en", {ram_en, ram_we}, 2'b00);
      check("init_trunc", trunc, 1'b0);
      check("init_frame_len", frame_len, 0);
      held        = 1'b0;
      pend_sready = 1'b0;
    end else begin
      if (trunc) seen_trunc++;
      if (pend_sready) begin
        check("s_ready_after_last", s_ready, 1'b1);
        pend_sready = 1'b0;
      end
      if (m_valid) check("no_overlap_s_ready", s_ready, 1'b0);
      if (s_valid && !s_ready) check("no_write_when_busy", ram_we, 1'b0);
      if (held && m_valid) check("stall_data_stable", m_data, held_data);
      held = 1'b0;
      if (m_valid && !prev_mv) begin
        if (exp_q.size() == 0) check("unexpected_frame", 32'd1, 32'd0);
        else begin
          check("first_is_head", exp_q[0].first, 1'b1);
          check("close_to_valid_lat", cyc - exp_q[0].close_cyc, 2);
        end
      end
      if (m_valid && rst_n) begin
        if (m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("m_data", m_data, e.data);
            check("m_last", m_last, e.last);
            check("frame_len", frame_len, e.len);
            if (e.last) pend_sready = 1'b1;
          end
        end else begin
          check("stall_ram_en", ram_en, 1'b0);
          held      = 1'b1;
          held_data = m_data;
        end
      end
    end
    prev_mv  = m_valid;
    prev_rst = rst_n;
  end

  initial begin
    int len;
    int n;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Three-word frame, always ready.
    rmode = 0;
    send_word(16'h1111, 1'b0, 0);
    send_word(16'h2222, 1'b0, 0);
    send_word(16'h3333, 1'b1, 0);
    wait_idle();

    // 64 words without s_last: closed by full RAM, truncation pulse.
    for (int i = 0; i < DP; i++) send_word(DW'(i), 1'b0, 0);
    wait_idle();

    // Backpressure on a 4-word frame; the next frame is offered at once so
    // s_valid stays high during drain.
    rmode = 1;
    for (int i = 0; i < 4; i++) send_word(DW'($urandom), i == 3, 0);
    send_word(16'hBEEF, 1'b1, 0);
    wait_idle();

    // Randomized frames, some longer than the RAM.
    rmode = 2;
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 80);
      for (int i = 0; i < len; i++)
        send_word(DW'($urandom), i == len - 1, $urandom_range(0, 2));
    end
    // A full-length frame ending exactly on the last RAM word: no truncation.
    for (int i = 0; i < DP; i++) send_word(DW'($urandom), i == DP - 1, 0);
    wait_idle();

    // Reset while word 2 of a 5-word frame is being presented.
    rmode = 0;
    for (int i = 0; i < 5; i++) send_word(DW'(16'hA000 + i), i == 4, 0);
    n = 0;
    while (exp_q.size() != 3 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reached_word2", exp_q.size(), 3);
    rst_n = 1'b0;
    exp_q.delete();
    cur_words.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_word(16'h5A5A, 1'b0, 0);
    send_word(16'hA5A5, 1'b1, 0);
    wait_idle();

    check("trunc_count", seen_trunc, exp_trunc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
